calc_disp_ctrl: RTL and testbench

CALC_DISP_CTRL -- requirements
Module: calc_disp_ctrl

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/calc_disp_ctrl.sv | 160 ++++++++++++++++
 tb/tb_calc_disp_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display controller.
// Op codes, FSM states, digit enables and the 7-segment table.
package calc_pkg;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  localparam int CONV_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CONV,
    ST_SHOW
  } state_t;

  localparam logic [3:0] SEL_OFF  = 4'b1111;
  localparam logic [3:0] SEL_THOU = 4'b1110;
  localparam logic [3:0] SEL_HUND = 4'b1101;
  localparam logic [3:0] SEL_TENS = 4'b1011;
  localparam logic [3:0] SEL_ONES = 4'b0111;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter.
// One bit per cycle; valid pulses once after the last shift.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        valid
);

  logic [19:0] r_sh;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_valid;
  logic [19:0] w_adj;
  logic        w_last;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    w_adj         = r_sh;
    w_adj[19:16]  = add3(r_sh[19:16]);
    w_adj[15:12]  = add3(r_sh[15:12]);
    w_adj[11:8]   = add3(r_sh[11:8]);
  end

  assign w_last = (r_cnt == 3'(CONV_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (load) begin
        r_sh   <= {12'd0, bin};
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_sh  <= {w_adj[18:0], 1'b0};
        r_cnt <= r_cnt + 3'd1;
        if (w_last) begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bcd   = r_sh[19:8];
  assign valid = r_valid;

endmodule

// File: rtl/calc_disp_ctrl.sv
// 4-bit calculator with BCD conversion and a multiplexed
// four-digit 7-segment display.
module calc_disp_ctrl
  import calc_pkg::*;
#(
  parameter int SCAN_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       sign_out,
  output logic [3:0] seg_sel,
  output logic [6:0] seg_out
);

  state_t r_state;
  state_t w_next;

  logic [3:0]        r_a;
  logic [3:0]        r_b;
  logic [1:0]        r_op;
  logic [2:0]        r_cnt;
  logic [7:0]        r_result;
  logic              r_sign;
  logic [SCAN_W-1:0] r_pre;
  logic [1:0]        r_idx;

  logic        w_accept;
  logic        w_cnt_last;
  logic        w_show;
  logic [7:0]  w_alu;
  logic        w_neg;
  logic [11:0] w_bcd;
  logic        w_valid;
  logic [3:0]  w_digit;

  assign w_show   = (r_state == ST_SHOW);
  assign w_accept = start &&
                    (r_state == ST_IDLE || w_show);
  assign w_cnt_last =
    (r_cnt == 3'(CONV_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_CALC;
      ST_CALC: w_next = ST_CONV;
      ST_CONV: if (w_cnt_last) w_next = ST_SHOW;
      ST_SHOW: if (w_accept) w_next = ST_CALC;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_alu = '0;
    w_neg = 1'b0;
    unique case (r_op)
      OP_ADD: w_alu = {4'd0, r_a} + {4'd0, r_b};
      OP_SUB: begin
        if (r_a < r_b) begin
          w_alu = {4'd0, r_b - r_a};
          w_neg = 1'b1;
        end else begin
          w_alu = {4'd0, r_a - r_b};
        end
      end
      OP_MUL: w_alu = {4'd0, r_a} * {4'd0, r_b};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ZERO;
      r_cnt    <= '0;
      r_result <= '0;
      r_sign   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
      if (r_state == ST_CALC) begin
        r_result <= w_alu;
        r_sign   <= w_neg;
        r_cnt    <= '0;
      end else if (r_state == ST_CONV) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  // Scan counters idle at zero outside SHOW, so entry starts on digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (!w_show) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (&r_pre) r_idx <= r_idx + 2'd1;
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (r_state == ST_CALC),
    .bin   (w_alu),
    .bcd   (w_bcd),
    .valid (w_valid)
  );

  always_comb begin
    w_digit = 4'd0;
    seg_sel = SEL_OFF;
    seg_out = SEG_BLANK;
    if (w_show) begin
      unique case (r_idx)
        2'd0: begin
          seg_sel = SEL_THOU;
          w_digit = 4'd0;
        end
        2'd1: begin
          seg_sel = SEL_HUND;
          w_digit = w_bcd[11:8];
        end
        2'd2: begin
          seg_sel = SEL_TENS;
          w_digit = w_bcd[7:4];
        end
        default: begin
          seg_sel = SEL_ONES;
          w_digit = w_bcd[3:0];
        end
      endcase
      seg_out = seg7(w_digit);
    end
  end

  assign busy     = (r_state == ST_CALC) ||
                    (r_state == ST_CONV);
  assign done     = w_show && w_valid;
  assign result   = r_result;
  assign sign_out = r_sign;

endmodule

// File: tb/tb_calc_disp_ctrl.sv
// Scoreboard bench for calc_disp_ctrl with a timeline reference model.
// Stimulus pushes expected results; a negedge monitor checks outputs.
module tb_calc_disp_ctrl;

  localparam int SW = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a     = '0;
  logic [3:0] b     = '0;
  logic [1:0] op    = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       sign_out;
  logic [3:0] seg_sel;
  logic [6:0] seg_out;

  calc_disp_ctrl #(.SCAN_W(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .sign_out (sign_out),
    .seg_sel  (seg_sel),
    .seg_out  (seg_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int acc;
    int res;
    bit neg;
  } exp_t;

  exp_t q[$];

  // Model: edge index of the last accepted start and its result.
  bit have_l  = 1'b0;
  int l_acc   = 0;
  int cur_res = 0;

  logic [6:0] seg_tab [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };
  logic [3:0] sel_tab [0:3] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int digit_of(input int r, input int idx);
    case (idx)
      0:       return 0;
      1:       return r / 100;
      2:       return (r / 10) % 10;
      default: return r % 10;
    endcase
  endfunction

  int   m_t;
  int   m_idx;
  bit   m_show;
  exp_t m_e;

  always @(negedge clk) begin
    m_show = have_l && (cyc >= l_acc + 9);
    chk("busy", busy,
        have_l && cyc >= l_acc && cyc <= l_acc + 8);
    chk("done", done, have_l && cyc == l_acc + 9);
    if (m_show) begin
      m_t   = cyc - (l_acc + 9);
      m_idx = (m_t >> SW) % 4;
      chk("seg_sel", seg_sel, sel_tab[m_idx]);
      chk("seg_out", seg_out,
          seg_tab[digit_of(cur_res, m_idx)]);
    end else begin
      chk("seg_sel_blank", seg_sel, 4'b1111);
      chk("seg_out_blank", seg_out, 7'b1111111);
    end
    if (done === 1'b1) begin
      chk("done_has_expect", q.size() > 0, 1);
      if (q.size() > 0) begin
        m_e = q.pop_front();
        chk("latency", cyc - m_e.acc + 1, 10);
        chk("result", result, m_e.res);
        chk("sign_out", sign_out, m_e.neg);
      end
    end
  end

  task automatic issue(input int ia, input int ib,
                       input int iop, output bit acc);
    int n;
    int r;
    bit ng;
    @(negedge clk);
    #1;
    a     = 4'(ia);
    b     = 4'(ib);
    op    = 2'(iop);
    start = 1'b1;
    n     = cyc + 1;
    acc   = !have_l || (n >= l_acc + 10);
    if (acc) begin
      ng = 1'b0;
      case (iop)
        0: r = 0;
        1: r = ia + ib;
        2: begin
          r  = (ia >= ib) ? ia - ib : ib - ia;
          ng = (ia < ib);
        end
        default: r = ia * ib;
      endcase
      have_l  = 1'b1;
      l_acc   = n;
      cur_res = r;
      q.push_back('{n, r, ng});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    op    = 2'($urandom);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'd0);
    chk("rst_sign", sign_out, 1'b0);
    chk("rst_seg_sel", seg_sel, 4'b1111);
    chk("rst_seg_out", seg_out, 7'b1111111);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    have_l  = 1'b0;
    cur_res = 0;
    q.delete();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  bit acc;

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    issue(9, 7, 1, acc);
    idle(30);
    issue(3, 12, 2, acc);
    idle(30);
    issue(15, 15, 3, acc);
    idle(30);
    issue($urandom_range(0, 15), $urandom_range(0, 15), 0, acc);
    idle(30);

    // Starts during CONV cycles 3 and 7 must be ignored.
    issue(5, 6, 1, acc);
    idle(3);
    issue(1, 2, 3, acc);
    idle(3);
    issue(14, 13, 2, acc);
    idle(30);

    // Reset during CONV cycle 4, then a clean run.
    issue(8, 9, 3, acc);
    idle(4);
    do_reset();
    issue(7, 7, 1, acc);
    idle(30);

    // Restart while showing.
    issue(12, 5, 2, acc);
    idle(14);
    issue(6, 9, 2, acc);
    idle(30);

    repeat (60) begin
      issue($urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3), acc);
      idle($urandom_range(0, 14));
    end
    idle(30);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
